// File: rtl/shifter_pkg.sv
// Shared definitions for the sequential shift/rotate unit.
//   - state_e : controller states (IDLE, SHIFT, DONE)
//   - mode_e  : decoded shift/rotate mode
//   - decode_mode() : maps {rotate, sra, op} request bits to mode_e
package shifter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    MODE_SLL = 3'd0,
    MODE_SRL = 3'd1,
    MODE_SRA = 3'd2,
    MODE_ROL = 3'd3,
    MODE_ROR = 3'd4
  } mode_e;

  // Rotate has priority over sra; sra only matters for right non-rotate.
  function automatic mode_e decode_mode(input logic rotate, input logic sra, input logic op);
    mode_e m;
    if (rotate)   m = op ? MODE_ROR : MODE_ROL;
    else if (!op) m = MODE_SLL;
    else if (sra) m = MODE_SRA;
    else          m = MODE_SRL;
    return m;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-chunk shifter/rotator.
//   data_i : operand (WIDTH)
//   amt_i  : shift amount, 0..STEP of the parent (AW bits, covers up to WIDTH)
//   mode_i : decoded mode
//   data_o : shifted/rotated result (WIDTH)
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AW    = 6
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [AW-1:0]    amt_i,
  input  mode_e            mode_i,
  output logic [WIDTH-1:0] data_o
);

  localparam logic [AW-1:0] WIDTH_A = AW'(WIDTH);

  logic [AW-1:0] inv_amt;

  // For amt_i = 0 the complementary shift is by WIDTH, which yields zero,
  // so the rotate degenerates cleanly to a passthrough.
  assign inv_amt = WIDTH_A - amt_i;

  always_comb begin
    data_o = data_i;
    case (mode_i)
      MODE_SLL: data_o = data_i << amt_i;
      MODE_SRL: data_o = data_i >> amt_i;
      MODE_SRA: data_o = $signed(data_i) >>> amt_i;
      MODE_ROL: data_o = (data_i << amt_i) | (data_i >> inv_amt);
      MODE_ROR: data_o = (data_i >> amt_i) | (data_i << inv_amt);
      default:  data_o = data_i;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit: applies at most STEP bit positions per clock.
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready     : request handshake
//   in_data, in_shamt     : operand and shift amount
//   in_op, in_sra, in_rotate : direction (0=left), arithmetic select, rotate select
//   out_valid/out_ready   : result handshake
//   out_data              : result
//   busy                  : high in SHIFT or DONE
//
// state | meaning
// IDLE  | ready for a request
// SHIFT | applying chunks of up to STEP bits, remaining counts down to zero
// DONE  | result held on out_data until out_ready
module seq_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic             in_op,
  input  logic             in_sra,
  input  logic             in_rotate,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  // One extra bit so STEP itself is representable even when STEP = WIDTH.
  localparam int AW = SHW + 1;
  localparam logic [AW-1:0] STEP_A = AW'(STEP);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SHW-1:0]   rem_q, rem_d;
  mode_e            mode_q, mode_d;

  logic [AW-1:0]    rem_ext;
  logic [AW-1:0]    chunk;
  logic [WIDTH-1:0] step_out;

  assign rem_ext = {1'b0, rem_q};
  assign chunk   = (rem_ext < STEP_A) ? rem_ext : STEP_A;

  shift_step #(
    .WIDTH(WIDTH),
    .AW   (AW)
  ) u_shift_step (
    .data_i(data_q),
    .amt_i (chunk),
    .mode_i(mode_q),
    .data_o(step_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      mode_q  <= MODE_SLL;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    rem_d     = rem_q;
    mode_d    = mode_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          data_d  = in_data;
          rem_d   = in_shamt;
          mode_d  = decode_mode(in_rotate, in_sra, in_op);
          state_d = (in_shamt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        data_d = step_out;
        rem_d  = SHW'(rem_ext - chunk);
        if (rem_d == '0) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign out_data = data_q;

endmodule

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
- Multi-cycle, parametrised shift/rotate unit for the datapath ALU; the sequential successor to the fixed 32-bit, 4-bit-step shift slice.
- Accepts an operand, shift amount and mode over a valid/ready handshake.
- Applies at most STEP bit positions per clock.
- Returns the result over a valid/ready handshake, trading latency for a small per-cycle shifter.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of two, at least 8.
- STEP, 4, maximum shift applied per cycle; must be a power of two, 1 to WIDTH.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  unit can accept a request.
- in_data  input  WIDTH  operand.
- in_shamt  input  SHW  shift amount, 0 to WIDTH-1.
- in_op  input  1  direction: 0 = left, 1 = right.
- in_sra  input  1  arithmetic select; effective only for right non-rotate operations.
- in_rotate  input  1  rotate select; has priority over in_sra.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  result.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset: asynchronous, active-low, single clock domain.
  - While rst_n = 0: state = IDLE, in_ready = 1, out_valid = 0, busy = 0, out_data = 0, internal registers = 0.
  - Reset mid-operation discards the operation silently; there is no partial result.
- Mode decode:
  - rotate = 1: rotate in direction op; sra ignored.
  - rotate = 0, op = 1, sra = 1: arithmetic right, MSB replicated.
  - rotate = 0, op = 1, sra = 0: logical right, zero fill.
  - rotate = 0, op = 0: logical left, zero fill; sra ignored.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid = 1, the unit latches data, shamt into remaining, and mode.
  - Next state is SHIFT if shamt != 0, otherwise DONE.
- SHIFT:
  - Each edge applies a chunk c = min(remaining, STEP) and sets remaining -= c.
  - When the post-update remaining = 0, next state is DONE.
- DONE:
  - out_valid = 1; out_data is the final register value.
  - On an edge with out_ready = 1, next state is IDLE.
  - Otherwise all outputs hold stable; full backpressure is supported.
- Latency:
  - With K = ceil(shamt/STEP), out_valid rises in the cycle after edge T+K, where T is the accept edge.
  - shamt = 0 gives a 1-cycle passthrough.
- Throughput:
  - in_ready = 0 in SHIFT and DONE; there is no accept-while-done bypass.
  - in_valid and the input buses are ignored outside IDLE.
  - Minimum request spacing is K+2 cycles.
- Multi-chunk rotate is exact; the composition of chunks equals a single rotate by shamt.
- Arithmetic right: the sign comes from the current MSB each chunk, which equals the original sign.
- out_ready outside DONE has no effect.
- in_shamt has no out-of-range value, because it is SHW bits wide.

Decomposition:
- Package shifter_pkg:
  - FSM state encoding constants (IDLE, SHIFT, DONE).
  - Mode encoding (MODE_SLL, MODE_SRL, MODE_SRA, MODE_ROL, MODE_ROR) and a decode function from {rotate, sra, op}.
- One sub-module, shift_step:
  - Combinational, WIDTH-wide.
  - Shifts or rotates by an amount 0 to STEP in the decoded mode.
  - Instantiated once in the datapath.

Test Plan:
- SLL, a=0x12345678, shamt=4, op=0, sra=1, rotate=0 -> out_data=0x23456780; out_valid after edge T+1.
- SRA, a=0x87654321, shamt=9, op=1, sra=1 -> out_data=0xFFC3B2A1, K=3. Same operand with sra=0 -> 0x0043B2A1.
- ROR, a=0xFEDCBA98, shamt=12, op=1, rotate=1, sra=1 -> 0xA98FEDCB (rotate wins), K=3.
- Two back-to-back requests:
  - ROL, a=0x00000001, shamt=31 -> 0x80000000, K=8.
  - Then shamt=0, a=0xC0FFEE01 -> 0xC0FFEE01 one cycle after accept.
  - in_ready low throughout busy.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, out_data and busy stable, in_ready=0. A concurrent in_valid pulse is not accepted.
- Reset mid-SHIFT: assert rst_n=0 asynchronously between edges -> out_valid=0, in_ready=1 immediately. After release, a new SLL of 0xF0F0F0F0 by 8 -> 0xF0F0F000.
